// File: rtl/bcd_value_ctrl_pkg.sv
// Shared types and constants for the BCD display value controller.
// No logic; combinational helper only (zero latency).
// No flow control of its own.
package bcd_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int WORD_W     = NUM_DIGITS * DIGIT_W;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [IDX_W-1:0]   LAST_IDX      = IDX_W'(NUM_DIGITS - 1);

    typedef logic [WORD_W-1:0] bcd_word_t;

    typedef enum logic [1:0] {
        IDLE,
        INC,
        DEC,
        COMMIT
    } state_t;

    // True when every nibble of the word is a legal decimal digit.
    function automatic logic is_bcd_word(input bcd_word_t w);
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (w[d*DIGIT_W +: DIGIT_W] > BCD_MAX_DIGIT) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_value_ctrl_if.sv
// Load handshake and display-side status bundle of the BCD value controller.
// Wires only, no latency.
// Load uses valid/ready; status outputs are unconditioned pulses/levels.
interface bcd_value_ctrl_if;
    import bcd_pkg::*;

    logic      load_valid;
    bcd_word_t load_bcd;
    logic      load_ready;
    bcd_word_t bcd;
    logic      busy;
    logic      update;
    logic      wrap;
    logic      load_err;

    // UART side: offers loads, observes the committed value and status.
    modport master (
        output load_valid, load_bcd,
        input  load_ready, bcd, busy, update, wrap, load_err
    );

    // Controller side.
    modport slave (
        input  load_valid, load_bcd,
        output load_ready, bcd, busy, update, wrap, load_err
    );

endinterface

// File: rtl/bcd_value_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability debouncer, press-edge pulse.
// Press pulse appears 2 + DEBOUNCE_CYCLES clocks after a clean raw rising edge.
// No backpressure: press pulses are one cycle wide and lost if not consumed.
// Optional auto-repeat under BTN_AUTOREPEAT_EN.
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd1000000
`endif
) (
    input  logic i_iclk,
    input  logic i_rst_n,
    input  logic i_raw,
`ifdef BTN_AUTOREPEAT_EN
    input  logic i_other_lvl,
    output logic o_level,
`endif
    output logic o_press
);

    logic        sync_q1;
    logic        sync_q2;
    logic        level_q;
    logic        press_q;
    logic [15:0] cnt_q;
`ifdef BTN_AUTOREPEAT_EN
    logic [23:0] rpt_cnt_q;
    logic        rpt_first_q;
`endif

    // Synchronize, require a run of identical differing samples, emit a pulse on 0->1.
    always_ff @(posedge i_iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q1     <= 1'b0;
            sync_q2     <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
`endif
        end else begin
            sync_q1 <= i_raw;
            sync_q2 <= sync_q1;
            press_q <= 1'b0;
            // Any sample matching the current level is a bounce and restarts the run.
            if (sync_q2 != level_q) begin
                if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                    level_q <= sync_q2;
                    cnt_q   <= '0;
                    press_q <= sync_q2;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end else begin
                cnt_q <= '0;
            end
`ifdef BTN_AUTOREPEAT_EN
            // Hold timer: long first delay, then a shorter period; chords cancel it.
            if (!level_q || i_other_lvl) begin
                rpt_cnt_q   <= '0;
                rpt_first_q <= 1'b1;
            end else if (rpt_first_q ? (rpt_cnt_q == REPEAT_DELAY - 24'd1)
                                     : (rpt_cnt_q == REPEAT_PERIOD - 24'd1)) begin
                press_q     <= 1'b1;
                rpt_cnt_q   <= '0;
                rpt_first_q <= 1'b0;
            end else begin
                rpt_cnt_q <= rpt_cnt_q + 24'd1;
            end
`endif
        end
    end

    assign o_press = press_q;
`ifdef BTN_AUTOREPEAT_EN
    assign o_level = level_q;
`endif

endmodule

// File: rtl/bcd_value_ctrl.sv
// Owns the 8-digit BCD display value; UART loads and debounced +1/-1 presses update it.
// Load: value visible the cycle after handshake. Inc/dec: k digits -> busy k+1 cycles, value at T+k+2.
// load_ready is low while a digit-serial sequence runs; presses arriving then are dropped.
// Optional button auto-repeat under BTN_AUTOREPEAT_EN.
module bcd_value_ctrl
    import bcd_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd1000000
`endif
) (
    input  logic             i_iclk,
    input  logic             i_rst_n,
    input  logic             i_SW_pos,
    input  logic             i_SW_neg,
    bcd_value_ctrl_if.slave  bus
);

    logic pos_press;
    logic neg_press;
`ifdef BTN_AUTOREPEAT_EN
    logic pos_level;
    logic neg_level;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_btn_pos (
        .i_iclk      (i_iclk),
        .i_rst_n     (i_rst_n),
        .i_raw       (i_SW_pos),
`ifdef BTN_AUTOREPEAT_EN
        .i_other_lvl (neg_level),
        .o_level     (pos_level),
`endif
        .o_press     (pos_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_btn_neg (
        .i_iclk      (i_iclk),
        .i_rst_n     (i_rst_n),
        .i_raw       (i_SW_neg),
`ifdef BTN_AUTOREPEAT_EN
        .i_other_lvl (pos_level),
        .o_level     (neg_level),
`endif
        .o_press     (neg_press)
    );

    state_t               state_q;
    bcd_word_t            bcd_q;
    bcd_word_t            work_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 busy_q;
    logic                 update_q;
    logic                 wrap_q;
    logic                 load_err_q;
    logic                 ready_q;
    logic [DIGIT_W-1:0]   cur_digit;

    assign cur_digit = work_q[idx_q*DIGIT_W +: DIGIT_W];

    // Arbitrate in IDLE, ripple one digit per cycle in INC/DEC, publish in COMMIT.
    always_ff @(posedge i_iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            bcd_q      <= '0;
            work_q     <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            update_q   <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            update_q   <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load_valid && ready_q) begin
                        // A malformed word is dropped whole; the display never shows it.
                        if (is_bcd_word(bus.load_bcd)) begin
                            bcd_q    <= bus.load_bcd;
                            update_q <= 1'b1;
                        end else begin
                            load_err_q <= 1'b1;
                        end
                        ready_q <= 1'b1;
                    end else if (pos_press ^ neg_press) begin
                        // Simultaneous pos/neg presses cancel each other.
                        work_q  <= bcd_q;
                        idx_q   <= '0;
                        state_q <= pos_press ? INC : DEC;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                INC: begin
                    if (cur_digit < BCD_MAX_DIGIT) begin
                        work_q[idx_q*DIGIT_W +: DIGIT_W] <= cur_digit + 4'd1;
                        state_q  <= COMMIT;
                        update_q <= 1'b1;
                    end else begin
                        work_q[idx_q*DIGIT_W +: DIGIT_W] <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q  <= COMMIT;
                            update_q <= 1'b1;
                            wrap_q   <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                DEC: begin
                    if (cur_digit != '0) begin
                        work_q[idx_q*DIGIT_W +: DIGIT_W] <= cur_digit - 4'd1;
                        state_q  <= COMMIT;
                        update_q <= 1'b1;
                    end else begin
                        work_q[idx_q*DIGIT_W +: DIGIT_W] <= BCD_MAX_DIGIT;
                        if (idx_q == LAST_IDX) begin
                            state_q  <= COMMIT;
                            update_q <= 1'b1;
                            wrap_q   <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    // The update pulse is already up for this cycle; the value lands at its end.
                    bcd_q   <= work_q;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready = ready_q;
    assign bus.bcd        = bcd_q;
    assign bus.busy       = busy_q;
    assign bus.update     = update_q;
    assign bus.wrap       = wrap_q;
    assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_bcd_value_ctrl.sv
// Scoreboard bench for bcd_value_ctrl: stimulus pushes expected events, a monitor pops them.
// Runs with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Auto-repeat scenario included when BTN_AUTOREPEAT_EN is defined.
module tb_bcd_value_ctrl;
    import bcd_pkg::*;

    logic i_iclk  = 1'b0;
    logic i_rst_n = 1'b0;
    logic sw_pos  = 1'b0;
    logic sw_neg  = 1'b0;

    bcd_value_ctrl_if bus();

    bcd_value_ctrl #(
        .DEBOUNCE_CYCLES (16'd4)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (24'd20),
        .REPEAT_PERIOD   (24'd8)
`endif
    ) dut (
        .i_iclk   (i_iclk),
        .i_rst_n  (i_rst_n),
        .i_SW_pos (sw_pos),
        .i_SW_neg (sw_neg),
        .bus      (bus)
    );

    always #5 i_iclk = ~i_iclk;

    typedef struct {
        logic        is_err;
        logic [31:0] bcd;
        logic        wrap;
        int          busy;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model  = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_iclk);
        #1;
    endtask

    task automatic push_exp(input logic is_err, input logic [31:0] v, input logic w, input int b);
        exp_t e;
        e.is_err = is_err;
        e.bcd    = v;
        e.wrap   = w;
        e.busy   = b;
        exp_q.push_back(e);
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!bus.busy && n < 30) begin
            @(negedge i_iclk);
            n++;
        end
        check(name, 32'(bus.busy), 32'd1);
    endtask

    // Offer a load; ok is the hand-decided legality of the word.
    task automatic do_load(input logic [31:0] v, input logic ok);
        int n = 0;
        if (ok) begin
            push_exp(1'b0, v, 1'b0, 0);
            model = v;
        end else begin
            push_exp(1'b1, model, 1'b0, 0);
        end
        bus.load_bcd   = v;
        bus.load_valid = 1'b1;
        do begin
            @(negedge i_iclk);
            n++;
        end while (!bus.load_ready && n < 50);
        check("load_handshake", 32'(bus.load_ready), 32'd1);
        @(posedge i_iclk);
        #1;
        bus.load_valid = 1'b0;
        tick(3);
    endtask

    // Hold the given buttons for hold cycles; expect one sequence when evt is set.
    task automatic press(input logic p, input logic n, input int hold, input logic evt,
                         input logic [31:0] v, input logic w, input int b);
        if (evt) begin
            push_exp(1'b0, v, w, b);
            model = v;
        end
        sw_pos = p;
        sw_neg = n;
        tick(hold);
        sw_pos = 1'b0;
        sw_neg = 1'b0;
        tick(25);
    endtask

    // Monitor: pop one expectation per update / load_err pulse.
    initial begin : monitor
        int          bcnt;
        logic        pend;
        logic [31:0] pend_val;
        exp_t        e;
        bcnt     = 0;
        pend     = 1'b0;
        pend_val = 32'h0;
        forever begin
            @(negedge i_iclk);
            if (pend) begin
                check("bcd_after_update", bus.bcd, pend_val);
                pend = 1'b0;
            end
            if (!i_rst_n || !bus.busy) bcnt = 0;
            else                       bcnt++;
            if (bus.update || bus.load_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: update=%0b load_err=%0b bcd=0x%08h, expected none",
                             bus.update, bus.load_err, bus.bcd);
                end else begin
                    e = exp_q.pop_front();
                    check("update_pulse", 32'(bus.update), 32'(!e.is_err));
                    check("load_err_pulse", 32'(bus.load_err), 32'(e.is_err));
                    check("wrap_pulse", 32'(bus.wrap), 32'(e.wrap));
                    check("busy_cycles_at_update", 32'(bcnt), 32'(e.busy));
                    if (e.is_err) begin
                        check("bcd_after_err", bus.bcd, e.bcd);
                    end else begin
                        pend     = 1'b1;
                        pend_val = e.bcd;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic rdy_in_busy;
        int   n;
        bus.load_valid = 1'b0;
        bus.load_bcd   = 32'h0;

        // Reset values.
        tick(3);
        check("rst_bcd", bus.bcd, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_update", 32'(bus.update), 32'd0);
        check("rst_wrap", 32'(bus.wrap), 32'd0);
        check("rst_load_err", 32'(bus.load_err), 32'd0);
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        i_rst_n = 1'b1;
        tick(1);
        check("ready_after_release", 32'(bus.load_ready), 32'd1);

        // 129 + 1 touches two digits.
        do_load(32'h0000_0129, 1'b1);
        press(1'b1, 1'b0, 10, 1'b1, 32'h0000_0130, 1'b0, 3);

        // Full-width wrap both ways.
        do_load(32'h9999_9999, 1'b1);
        press(1'b1, 1'b0, 10, 1'b1, 32'h0000_0000, 1'b1, 9);
        press(1'b0, 1'b1, 10, 1'b1, 32'h9999_9999, 1'b1, 9);

        // Illegal digit 0xA is rejected.
        do_load(32'h0000_001A, 1'b0);
        check("bcd_kept_after_bad_load", bus.bcd, 32'h9999_9999);

        // Bouncing press yields one increment.
        do_load(32'h0000_0041, 1'b1);
        push_exp(1'b0, 32'h0000_0042, 1'b0, 2);
        model  = 32'h0000_0042;
        sw_pos = 1'b1; tick(1);
        sw_pos = 1'b0; tick(1);
        sw_pos = 1'b1; tick(10);
        sw_pos = 1'b0; tick(25);

        // Both buttons together cancel.
        press(1'b1, 1'b1, 10, 1'b0, 32'h0, 1'b0, 0);
        check("bcd_after_chord", bus.bcd, 32'h0000_0042);

        // Load offered mid-sequence waits for the increment to commit.
        do_load(32'h0000_0199, 1'b1);
        push_exp(1'b0, 32'h0000_0200, 1'b0, 4);
        sw_pos = 1'b1;
        wait_busy("busy_for_inc_199");
        sw_pos = 1'b0;
        check("ready_low_while_busy", 32'(bus.load_ready), 32'd0);
        push_exp(1'b0, 32'h1234_5678, 1'b0, 0);
        bus.load_bcd   = 32'h1234_5678;
        bus.load_valid = 1'b1;
        rdy_in_busy = 1'b0;
        n = 0;
        while (!bus.load_ready && n < 50) begin
            @(negedge i_iclk);
            if (bus.busy && bus.load_ready) rdy_in_busy = 1'b1;
            n++;
        end
        check("ready_seen_during_busy", 32'(rdy_in_busy), 32'd0);
        check("late_load_handshake", 32'(bus.load_ready), 32'd1);
        check("inc_committed_before_load", bus.bcd, 32'h0000_0200);
        @(posedge i_iclk);
        #1;
        bus.load_valid = 1'b0;
        model = 32'h1234_5678;
        tick(25);

        // Reset during an 8-digit decrement aborts it.
        do_load(32'h1000_0000, 1'b1);
        sw_neg = 1'b1;
        tick(6);
        sw_neg = 1'b0;
        wait_busy("busy_for_dec_10000000");
        tick(3);
        i_rst_n = 1'b0;
        #1;
        check("abort_bcd", bus.bcd, 32'h0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_ready", 32'(bus.load_ready), 32'd0);
        tick(2);
        i_rst_n = 1'b1;
        model = 32'h0;
        tick(20);
        check("bcd_after_abort", bus.bcd, 32'h0);

`ifdef BTN_AUTOREPEAT_EN
        // Held press: initial event plus two repeats.
        push_exp(1'b0, 32'h0000_0001, 1'b0, 2);
        push_exp(1'b0, 32'h0000_0002, 1'b0, 2);
        push_exp(1'b0, 32'h0000_0003, 1'b0, 2);
        model  = 32'h0000_0003;
        sw_pos = 1'b1;
        tick(34);
        sw_pos = 1'b0;
        tick(40);
        check("autorepeat_bcd", bus.bcd, 32'h0000_0003);
`endif

        tick(5);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
